// File: rtl/intersection_traffic_model.sv
// Intersection model: per-lane car queues, sensors, departures, starvation and conflict flags (conflict detector built only with TLM_CONFLICT_CHECK_EN).
// Latency: arrival/departure visible on count and sensor 1 cycle after sampling; flags 1 cycle after the triggering sample.
// No backpressure: arrivals are pulses, and one offered to a full queue with no departure is dropped and flagged.
package light_package;
    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } light_t;
endpackage

module intersection_traffic_model
    import light_package::*;
#(
    parameter int QDEPTH       = 15,
    parameter int STARVE_LIMIT = 20
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ew_str_arrive,
    input  logic                        ew_left_arrive,
    input  logic                        ns_arrive,
    input  light_t                      ew_str_light,
    input  light_t                      ew_left_light,
    input  light_t                      ns_light,
    output logic                        ew_str_sensor,
    output logic                        ew_left_sensor,
    output logic                        ns_sensor,
    output logic [$clog2(QDEPTH+1)-1:0] ew_str_count,
    output logic [$clog2(QDEPTH+1)-1:0] ew_left_count,
    output logic [$clog2(QDEPTH+1)-1:0] ns_count,
    output logic [15:0]                 depart_total,
    output logic                        overflow,
    output logic [2:0]                  starve,
    output logic                        conflict
);
    localparam int CW = $clog2(QDEPTH+1);
    localparam int WW = $clog2(STARVE_LIMIT+1);
    localparam logic [CW-1:0] QMAX = CW'(QDEPTH);
    localparam logic [WW-1:0] WMAX = WW'(STARVE_LIMIT);

    // Lane index 2 = ew_str, 1 = ew_left, 0 = ns, matching the starve bit order.
    logic [2:0] arrive;
    logic [2:0] green;
    assign arrive = {ew_str_arrive, ew_left_arrive, ns_arrive};
    assign green  = {ew_str_light == GREEN, ew_left_light == GREEN, ns_light == GREEN};

    logic [CW-1:0] q      [3];
    logic [CW-1:0] q_next [3];
    logic [WW-1:0] w      [3];
    logic [WW-1:0] w_next [3];
    logic [2:0]    depart;
    logic [2:0]    accept;
    logic [2:0]    drop;
    logic [2:0]    starve_hit;
    logic [15:0]   dep_add;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            depart[i] = green[i] && (q[i] != '0);
            accept[i] = arrive[i] && ((q[i] != QMAX) || depart[i]);
            drop[i]   = arrive[i] && !accept[i];
            q_next[i] = q[i];
            if (accept[i] && !depart[i]) begin
                q_next[i] = q[i] + CW'(1);
            end else if (!accept[i] && depart[i]) begin
                q_next[i] = q[i] - CW'(1);
            end
            w_next[i] = w[i];
            if (green[i] || (q[i] == '0)) begin
                w_next[i] = '0;
            end else if (w[i] != WMAX) begin
                w_next[i] = w[i] + WW'(1);
            end
            starve_hit[i] = (w_next[i] == WMAX);
        end
        dep_add = 16'(depart[0]) + 16'(depart[1]) + 16'(depart[2]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                q[i] <= '0;
                w[i] <= '0;
            end
            depart_total <= '0;
            overflow     <= 1'b0;
            starve       <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                q[i] <= q_next[i];
                w[i] <= w_next[i];
            end
            depart_total <= depart_total + dep_add;
            overflow     <= overflow | (|drop);
            starve       <= starve | starve_hit;
        end
    end

    // Sensors come straight from the queue registers, so they never see lights or arrivals combinationally.
    assign ew_str_count   = q[2];
    assign ew_left_count  = q[1];
    assign ns_count       = q[0];
    assign ew_str_sensor  = (q[2] != '0);
    assign ew_left_sensor = (q[1] != '0);
    assign ns_sensor      = (q[0] != '0);

`ifdef TLM_CONFLICT_CHECK_EN
    logic [2:0] nonred;
    logic       conflict_hit;
    logic       conflict_q;
    assign nonred       = {ew_str_light != RED, ew_left_light != RED, ns_light != RED};
    assign conflict_hit = (nonred[0] && nonred[1]) || (nonred[0] && nonred[2]) || (nonred[1] && nonred[2]);

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= conflict_q | conflict_hit;
        end
    end
    assign conflict = conflict_q;
`else
    assign conflict = 1'b0;
`endif

endmodule

// File: tb/tb_intersection_traffic_model.sv
// Self-checking bench for intersection_traffic_model: vector table, corner sequences, randomized run against a lane-count model.
module tb_intersection_traffic_model;
    import light_package::*;

    localparam int QD = 15;
    localparam int SL = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       ew_str_arrive, ew_left_arrive, ns_arrive;
    light_t     ew_str_light, ew_left_light, ns_light;
    logic       ew_str_sensor, ew_left_sensor, ns_sensor;
    logic [3:0] ew_str_count, ew_left_count, ns_count;
    logic [15:0] depart_total;
    logic       overflow;
    logic [2:0] starve;
    logic       conflict;

    always #5 clk = ~clk;

    intersection_traffic_model #(.QDEPTH(QD), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset(reset),
        .ew_str_arrive(ew_str_arrive), .ew_left_arrive(ew_left_arrive), .ns_arrive(ns_arrive),
        .ew_str_light(ew_str_light), .ew_left_light(ew_left_light), .ns_light(ns_light),
        .ew_str_sensor(ew_str_sensor), .ew_left_sensor(ew_left_sensor), .ns_sensor(ns_sensor),
        .ew_str_count(ew_str_count), .ew_left_count(ew_left_count), .ns_count(ns_count),
        .depart_total(depart_total), .overflow(overflow), .starve(starve), .conflict(conflict)
    );

`ifdef TLM_CONFLICT_CHECK_EN
    localparam int CONF_EN = 1;
`else
    localparam int CONF_EN = 0;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: cars waiting per lane (2 = ew_str, 1 = ew_left, 0 = ns).
    int m_cars [3];
    int m_wait [3];
    int m_total;
    int m_ovf;
    int m_starve [3];
    int m_conf;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit [2:0] arr, input light_t ls, input light_t ll, input light_t ln);
        light_t lt [3];
        int nonred;
        lt[2] = ls; lt[1] = ll; lt[0] = ln;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_cars[i] = 0; m_wait[i] = 0; m_starve[i] = 0;
            end
            m_total = 0; m_ovf = 0; m_conf = 0;
            return;
        end
        nonred = 0;
        for (int i = 0; i < 3; i++) begin
            int leaving;
            int joining;
            if (lt[i] != RED) nonred++;
            leaving = (lt[i] == GREEN && m_cars[i] > 0) ? 1 : 0;
            joining = (arr[i] && (m_cars[i] < QD || leaving == 1)) ? 1 : 0;
            if (arr[i] && joining == 0) m_ovf = 1;
            if (lt[i] == GREEN || m_cars[i] == 0) m_wait[i] = 0;
            else if (m_wait[i] < SL) m_wait[i]++;
            if (m_wait[i] == SL) m_starve[i] = 1;
            m_cars[i] = m_cars[i] + joining - leaving;
            m_total = (m_total + leaving) % 65536;
        end
        if (CONF_EN != 0 && nonred >= 2) m_conf = 1;
    endtask

    task automatic apply(input bit rst, input bit [2:0] arr, input light_t ls, input light_t ll, input light_t ln);
        reset = rst;
        ew_str_arrive = arr[2]; ew_left_arrive = arr[1]; ns_arrive = arr[0];
        ew_str_light = ls; ew_left_light = ll; ns_light = ln;
        model_step(rst, arr, ls, ll, ln);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".ew_str_count"}, int'(ew_str_count), m_cars[2]);
        check({tag, ".ew_left_count"}, int'(ew_left_count), m_cars[1]);
        check({tag, ".ns_count"}, int'(ns_count), m_cars[0]);
        check({tag, ".sensors"}, int'({ew_str_sensor, ew_left_sensor, ns_sensor}),
              (m_cars[2] != 0) * 4 + (m_cars[1] != 0) * 2 + (m_cars[0] != 0));
        check({tag, ".depart_total"}, int'(depart_total), m_total);
        check({tag, ".overflow"}, int'(overflow), m_ovf);
        check({tag, ".starve"}, int'(starve), m_starve[2] * 4 + m_starve[1] * 2 + m_starve[0]);
        check({tag, ".conflict"}, int'(conflict), m_conf);
    endtask

    function automatic light_t pick(input int green_pct);
        int r;
        r = $urandom_range(0, 99);
        if (r < green_pct) return GREEN;
        if (r < green_pct + 5) return YELLOW;
        return RED;
    endfunction

    typedef struct {
        bit     rst;
        bit [2:0] arr;
        light_t ls, ll, ln;
        int     e_ews, e_ewl, e_ns, e_total;
    } vec_t;

    vec_t tv [9];

    initial begin
        tv[0] = '{1'b1, 3'b100, RED,   RED, RED, 0, 0, 0, 0};
        tv[1] = '{1'b0, 3'b100, RED,   RED, RED, 1, 0, 0, 0};
        tv[2] = '{1'b0, 3'b100, RED,   RED, RED, 2, 0, 0, 0};
        tv[3] = '{1'b0, 3'b100, RED,   RED, RED, 3, 0, 0, 0};
        tv[4] = '{1'b0, 3'b000, GREEN, RED, RED, 2, 0, 0, 1};
        tv[5] = '{1'b0, 3'b000, GREEN, RED, RED, 1, 0, 0, 2};
        tv[6] = '{1'b0, 3'b000, GREEN, RED, RED, 0, 0, 0, 3};
        tv[7] = '{1'b0, 3'b000, GREEN, RED, RED, 0, 0, 0, 3};
        tv[8] = '{1'b0, 3'b000, GREEN, RED, RED, 0, 0, 0, 3};

        for (int i = 0; i < 9; i++) begin
            apply(tv[i].rst, tv[i].arr, tv[i].ls, tv[i].ll, tv[i].ln);
            check($sformatf("vec%0d.ew_str_count", i), int'(ew_str_count), tv[i].e_ews);
            check($sformatf("vec%0d.ew_left_count", i), int'(ew_left_count), tv[i].e_ewl);
            check($sformatf("vec%0d.ns_count", i), int'(ns_count), tv[i].e_ns);
            check($sformatf("vec%0d.sensors", i), int'({ew_str_sensor, ew_left_sensor, ns_sensor}),
                  (tv[i].e_ews != 0) * 4 + (tv[i].e_ewl != 0) * 2 + (tv[i].e_ns != 0));
            check($sformatf("vec%0d.depart_total", i), int'(depart_total), tv[i].e_total);
            check($sformatf("vec%0d.flags", i), int'({overflow, starve, conflict}), 0);
        end

        // Overflow on a full ns queue, then arrival plus green keeps it full.
        apply(1'b1, 3'b000, RED, RED, RED);
        for (int i = 0; i < QD; i++) apply(1'b0, 3'b001, RED, RED, RED);
        check("fill.ns_count", int'(ns_count), 15);
        check("fill.overflow", int'(overflow), 0);
        apply(1'b0, 3'b001, RED, RED, RED);
        check("ovf.ns_count", int'(ns_count), 15);
        check("ovf.overflow", int'(overflow), 1);
        apply(1'b0, 3'b001, RED, RED, GREEN);
        check("full_arr_green.ns_count", int'(ns_count), 15);
        check("full_arr_green.depart_total", int'(depart_total), 1);

        // ew_left starves after 20 cycles of red with one car waiting.
        apply(1'b1, 3'b000, RED, RED, RED);
        apply(1'b0, 3'b010, RED, RED, RED);
        for (int i = 0; i < SL - 1; i++) apply(1'b0, 3'b000, RED, RED, RED);
        check("starve.before_limit", int'(starve), 0);
        apply(1'b0, 3'b000, RED, RED, RED);
        check("starve.at_limit", int'(starve), 3'b010);
        apply(1'b0, 3'b000, RED, GREEN, RED);
        apply(1'b0, 3'b000, RED, GREEN, RED);
        check("starve.after_green", int'(starve), 3'b010);
        check("starve.ew_left_count", int'(ew_left_count), 0);

        // Two non-red lights in one cycle.
        apply(1'b1, 3'b000, RED, RED, RED);
        check("conflict.after_reset", int'(conflict), 0);
        apply(1'b0, 3'b000, GREEN, RED, YELLOW);
        check("conflict.set", int'(conflict), CONF_EN);
        apply(1'b0, 3'b000, RED, RED, RED);
        check("conflict.sticky", int'(conflict), CONF_EN);

        // Mid-stream reset discards queues and flags; arrivals during reset are ignored.
        apply(1'b1, 3'b000, RED, RED, RED);
        for (int i = 0; i < 7; i++) apply(1'b0, {i < 4, i < 2, 1'b1}, RED, RED, RED);
        for (int i = 0; i < 9; i++) apply(1'b0, 3'b001, RED, RED, RED);
        apply(1'b0, 3'b000, YELLOW, YELLOW, RED);
        check("midrst.counts", int'({ew_str_count, ew_left_count, ns_count}), {4'd4, 4'd2, 4'd15});
        check("midrst.overflow_set", int'(overflow), 1);
        apply(1'b1, 3'b111, GREEN, GREEN, GREEN);
        check("midrst.counts_cleared", int'({ew_str_count, ew_left_count, ns_count}), 0);
        check("midrst.outputs_cleared", int'({ew_str_sensor, ew_left_sensor, ns_sensor, depart_total, overflow, starve, conflict}), 0);
        apply(1'b0, 3'b000, RED, RED, RED);
        check("midrst.arrival_ignored", int'({ew_str_count, ew_left_count, ns_count}), 0);

        // Randomized run against the reference model, with varying green density.
        apply(1'b1, 3'b000, RED, RED, RED);
        check_model("rand.reset");
        for (int blk = 0; blk < 4; blk++) begin
            int gp;
            gp = (blk == 0) ? 2 : (blk == 1) ? 30 : (blk == 2) ? 60 : 15;
            for (int c = 0; c < 600; c++) begin
                bit rst;
                bit [2:0] arr;
                rst = ($urandom_range(0, 299) == 0);
                arr = 3'($urandom_range(0, 7));
                apply(rst, arr, pick(gp), pick(gp), pick(gp));
                check_model($sformatf("rand.b%0d.c%0d", blk, c));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
